// File: rtl/lw_sha_pkg.sv
// Shared types and helpers for the masked SHA state storage: each stored word
// carries a 2-bit tag and its data byte-rotated right by 8*tag.
package lw_sha_pkg;

  localparam int SHA_WORD_SIZE    = 32;
  localparam int SHA_NUM_WORDS    = 8;
  localparam int DIGEST_WORDS_256 = 8;
  localparam int DIGEST_WORDS_224 = 7;

  typedef logic [SHA_WORD_SIZE-1:0] word_t;
  typedef logic [1:0]               mask_tag_t;
  typedef logic [SHA_WORD_SIZE+1:0] masked_word_t;

  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_STREAM, RD_DONE} rd_state_e;

  // Amount is reduced mod the word size so a full-width rotate is the identity.
  function automatic word_t rotr_word(word_t x, int unsigned n);
    int unsigned s;
    s = n % SHA_WORD_SIZE;
    return (s == 0) ? x : ((x >> s) | (x << (SHA_WORD_SIZE - s)));
  endfunction

  function automatic word_t rotl_word(word_t x, int unsigned n);
    int unsigned s;
    s = n % SHA_WORD_SIZE;
    return (s == 0) ? x : ((x << s) | (x >> (SHA_WORD_SIZE - s)));
  endfunction

  function automatic masked_word_t mask_word(word_t x, mask_tag_t t);
    return {t, rotr_word(x, 8 * int'(t))};
  endfunction

endpackage

// File: rtl/sha_digest_reader_if.sv
// Digest readout stream: valid/ready word channel with end-of-stream marker.
interface sha_digest_reader_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] dout_o;
  logic                 dout_valid_o;
  logic                 dout_ready_i;
  logic                 dout_last_o;

  modport master (output dout_o, dout_valid_o, dout_last_o, input dout_ready_i);
  modport slave  (input dout_o, dout_valid_o, dout_last_o, output dout_ready_i);
endinterface

// File: rtl/sha_word_unmask.sv
// Combinational removal of the byte rotation from one masked state word.
module sha_word_unmask
  import lw_sha_pkg::*;
(
  input  masked_word_t masked_i,
  output word_t        plain_o
);
  assign plain_o = rotl_word(masked_i[SHA_WORD_SIZE-1:0],
                             8 * int'(masked_i[SHA_WORD_SIZE +: 2]));
endmodule

// File: rtl/sha_digest_reader.sv
// Snapshots the masked SHA state on start and streams the unmasked digest,
// H0 first, over a valid/ready channel (7 words in SHA-224 mode, else 8).
module sha_digest_reader
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = SHA_WORD_SIZE,
  parameter int NUM_WORDS = SHA_NUM_WORDS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic                               mode224_i,
  input  logic                               abort_i,
  input  logic [NUM_WORDS*(WORD_SIZE+2)-1:0] state_i,
  sha_digest_reader_if.master                dout_if,
  output logic                               busy_o,
  output logic                               done_o
);
  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam int MW = WORD_SIZE + 2;

  rd_state_e                           state_q, state_d;
  logic [NUM_WORDS-1:0][MW-1:0]        snap_q, snap_d;
  logic [NUM_WORDS-1:0][WORD_SIZE-1:0] plain;
  logic [IW-1:0]                       len_q, len_d, idx_q, idx_d, idx_inc, len_m1;
  logic [WORD_SIZE-1:0]                dout_q, dout_d, next_word;
  logic                                valid_q, valid_d, accept;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_unmask
    sha_word_unmask u_unmask (.masked_i(snap_q[g]), .plain_o(plain[g]));
  end

  assign idx_inc = idx_q + IW'(1);
  assign len_m1  = len_q - IW'(1);
  assign accept  = valid_q && dout_if.dout_ready_i;

  always_comb begin
    next_word = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      if (idx_inc == IW'(k)) next_word = plain[k];
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    len_d   = len_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    unique case (state_q)
      RD_IDLE: if (start_i) begin
        snap_d  = state_i;
        len_d   = mode224_i ? IW'(DIGEST_WORDS_224) : IW'(DIGEST_WORDS_256);
        idx_d   = '0;
        state_d = RD_LOAD;
      end
      RD_LOAD: begin
        dout_d  = plain[0];
        valid_d = 1'b1;
        state_d = RD_STREAM;
      end
      RD_STREAM: if (accept) begin
        if (idx_q == len_m1) begin
          dout_d  = '0;
          valid_d = 1'b0;
          state_d = RD_DONE;
        end else begin
          idx_d  = idx_inc;
          dout_d = next_word;
        end
      end
      RD_DONE: begin
        snap_d  = '0;
        len_d   = '0;
        idx_d   = '0;
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    // Flush wins over everything, including a same-cycle start.
    if (abort_i) begin
      state_d = RD_IDLE;
      snap_d  = '0;
      len_d   = '0;
      idx_d   = '0;
      dout_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      snap_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout_if.dout_o       = valid_q ? dout_q : '0;
  assign dout_if.dout_valid_o = valid_q;
  assign dout_if.dout_last_o  = valid_q && (idx_q == len_m1);
  assign busy_o               = (state_q == RD_LOAD) || (state_q == RD_STREAM);
  assign done_o               = (state_q == RD_DONE);

endmodule

// File: tb/tb_sha_digest_reader.sv
// Bench for sha_digest_reader: vector table plus directed stall/abort/reset runs,
// with a scoreboard of expected words checked on every handshake.
module tb_sha_digest_reader;

  logic         clk = 1'b0, rst_n = 1'b1;
  logic         start_i = 1'b0, mode224_i = 1'b0, abort_i = 1'b0;
  logic [271:0] state_i = '0;
  logic         busy_o, done_o;

  sha_digest_reader_if #(.WORD_SIZE(32)) dif ();

  sha_digest_reader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode224_i(mode224_i),
    .abort_i(abort_i), .state_i(state_i), .dout_if(dif),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; logic last; } exp_t;
  typedef struct {
    logic [7:0][33:0] st;
    logic             mode;
    logic [7:0][31:0] exp;
    int               n;
  } vec_t;

  int   checks = 0, failures = 0, hs_cnt = 0;
  exp_t sb[$];
  vec_t tbl[6];
  logic [7:0][31:0] iv256, iv224;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [33:0] mask(logic [31:0] x, logic [1:0] t);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < int'(t); i++) r = {r[7:0], r[31:8]};
    return {t, r};
  endfunction

  function automatic vec_t mk_rand(logic [7:0][31:0] iv, logic m, int n);
    vec_t v;
    for (int k = 0; k < 8; k++) v.st[k] = mask(iv[k], 2'($urandom_range(0, 3)));
    v.mode = m; v.exp = iv; v.n = n;
    return v;
  endfunction

  task automatic start_stream(vec_t v);
    @(posedge clk); #1;
    state_i = v.st; mode224_i = v.mode; start_i = 1'b1;
    for (int k = 0; k < v.n; k++) sb.push_back('{w: v.exp[k], last: (k == v.n - 1)});
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(string name, int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; break; end
    end
    chk(name, seen, 1'b1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic monitor();
    logic        prev_stall;
    logic [31:0] pd;
    logic        pl;
    exp_t        e;
    prev_stall = 1'b0; pd = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || abort_i) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("stall_valid", dif.dout_valid_o, 1'b1);
          chk("stall_data", dif.dout_o, pd);
          chk("stall_last", dif.dout_last_o, pl);
        end
        if (!dif.dout_valid_o) chk("idle_zero", {dif.dout_o, dif.dout_last_o}, '0);
        if (dif.dout_valid_o && dif.dout_ready_i) begin
          hs_cnt++;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_word actual=%h required=none", dif.dout_o);
          end else begin
            e = sb.pop_front();
            chk("word", dif.dout_o, e.w);
            chk("last", dif.dout_last_o, e.last);
          end
        end
        prev_stall = dif.dout_valid_o && !dif.dout_ready_i;
        pd = dif.dout_o; pl = dif.dout_last_o;
      end
    end
  endtask

  initial begin
    logic seen;
    int   base;
    int   pat[4] = '{1, 0, 0, 1};
    vec_t v;

    iv256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
             32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    iv224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
             32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

    // Tag sweep on H0 with literal stored forms; other words untagged.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) tbl[i].st[k] = {2'b00, iv256[k]};
      tbl[i].mode = 1'b0; tbl[i].exp = iv256; tbl[i].n = 8;
    end
    tbl[0].st[0] = {2'd0, 32'h6a09e667};
    tbl[1].st[0] = {2'd1, 32'h676a09e6};
    tbl[2].st[0] = {2'd2, 32'he6676a09};
    tbl[3].st[0] = {2'd3, 32'h09e6676a};
    tbl[4] = mk_rand(iv224, 1'b1, 7);
    tbl[5] = mk_rand(iv256, 1'b0, 8);

    fork monitor(); join_none

    dif.dout_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", dif.dout_valid_o, 1'b0);
    chk("rst_dout", dif.dout_o, '0);
    chk("rst_last", dif.dout_last_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 1'b0);
    dif.dout_ready_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_stream(tbl[i]);
      wait_done($sformatf("tbl%0d_done", i), 40);
    end

    // Cycle-exact SHA-256 run: start sampled at end of cycle 0.
    v = mk_rand(iv256, 1'b0, 8);
    start_stream(v);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("t256_valid_c%0d", i), dif.dout_valid_o, (i >= 2 && i <= 9));
      chk($sformatf("t256_last_c%0d", i), dif.dout_last_o, (i == 9));
      chk($sformatf("t256_done_c%0d", i), done_o, (i == 10));
      chk($sformatf("t256_busy_c%0d", i), busy_o, (i <= 9));
    end
    chk("t256_sb_empty", sb.size(), 0);

    // Ready 1-0-0-1 with a competing start mid-stream.
    start_stream(tbl[5]);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done_o) begin seen = 1'b1; break; end
      dif.dout_ready_i = pat[i % 4][0];
      start_i = (i == 4);
      if (i == 4) begin state_i = tbl[4].st; mode224_i = 1'b1; end
    end
    start_i = 1'b0; dif.dout_ready_i = 1'b1;
    chk("toggle_done", seen, 1'b1);
    chk("toggle_sb_empty", sb.size(), 0);

    // Abort right after the third handshake.
    start_stream(tbl[5]);
    base = hs_cnt; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (hs_cnt >= base + 3) begin seen = 1'b1; break; end
    end
    chk("abort_reach", seen, 1'b1);
    #1 abort_i = 1'b1; dif.dout_ready_i = 1'b0;
    @(posedge clk); #1 abort_i = 1'b0; dif.dout_ready_i = 1'b1;
    @(negedge clk);
    chk("abort_valid", dif.dout_valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_dout", dif.dout_o, '0);
    chk("abort_done", done_o, 1'b0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_o, 1'b0);
    end
    start_stream(tbl[0]);
    wait_done("post_abort_done", 40);

    // Asynchronous reset after the second handshake.
    start_stream(tbl[5]);
    base = hs_cnt; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (hs_cnt >= base + 2) begin seen = 1'b1; break; end
    end
    chk("rst_reach", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", dif.dout_valid_o, 1'b0);
    chk("mid_rst_dout", dif.dout_o, '0);
    chk("mid_rst_last", dif.dout_last_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    start_stream(tbl[4]);
    wait_done("post_rst_done", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
